mesi_bus_arbiter: RTL and testbench
===================================

MESI_BUS_ARBITER -- requirements
Module: mesi_bus_arbiter

Interface
REQ-001 Parameter SNOOP_CYCLES, default 2, number of cycles a bus command is broadcast for snooping (legal 1..15).
REQ-002 Parameter NUM_CORES, default 4, number of requesting cores (fixed at 4; other values unsupported).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req  input  4  per-core bus request, bit i = core i; held high until done[i].
REQ-007 req_ins_type  input  4  per-core access type, 0 = read, 1 = write.
REQ-008 req_hit  input  4  per-core L1 hit flag.
REQ-009 snoop_shared  input  1  wired-OR shared line from snooping caches.
REQ-010 grant  output  4  one-hot grant, held for the whole transaction.
REQ-011 bus_valid  output  1  bus command valid during SNOOP.
REQ-012 bus_signals  output  5  {core_id[1:0], BusRd, BusRdX, BusUpgr}.
REQ-013 done  output  4  one-hot single-cycle completion pulse.
REQ-014 shared_out  output  1  latched snoop_shared result, valid with done.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, GRANT, SNOOP and RESP.
REQ-017 IDLE with any req bit high SHALL pick a winner, latch its core_id, req_ins_type and req_hit, and go to GRANT next cycle.
REQ-018 Command encoding from latched type/hit: read miss -> 3'b100 (BusRd), write miss -> 3'b010 (BusRdX), write hit -> 3'b001 (BusUpgr), read hit -> 3'b000.
REQ-019 GRANT SHALL last one cycle, then go to SNOOP, or to RESP directly for a read hit.
REQ-020 SNOOP SHALL last exactly SNOOP_CYCLES cycles with bus_valid = 1 and bus_signals = {core_id, command}.
REQ-021 snoop_shared SHALL be sampled on the last SNOOP cycle; for a read hit, shared_out SHALL be 0.
REQ-022 RESP SHALL last one cycle with done[core_id] = 1, shared_out valid, then return to IDLE.
REQ-023 Latency: req seen in IDLE at cycle t -> grant at t+1 -> bus_valid t+2..t+1+SNOOP_CYCLES -> done at t+2+SNOOP_CYCLES (read hit: done at t+2).
REQ-024 grant SHALL be high from GRANT through RESP inclusive; bus_signals SHALL be 5'b0 outside SNOOP.
REQ-025 Round-robin: the search starts at pointer p (reset 0); after granting core k, p becomes (k+1) mod 4.
REQ-026 Dropping req mid-transaction SHALL NOT abort it; the transaction completes and done still pulses.
REQ-027 A req seen only during GRANT, SNOOP or RESP SHALL wait for the next IDLE; there are no back-to-back grants without an IDLE cycle.
REQ-028 Simultaneous requests from all four cores SHALL each be served exactly once within four transactions.

Reset
REQ-029 rst_n low SHALL force IDLE, grant = 0, bus_valid = 0, bus_signals = 0, done = 0, shared_out = 0, busy = 0 and p = 0, immediately (asynchronously).
REQ-030 A reset asserted mid-transaction SHALL drop the transaction with no done pulse.

Configuration
REQ-031 With MESI_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (core 0 highest, core 3 lowest) and p SHALL be unused.
REQ-032 Without MESI_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-025.

Structure
REQ-033 The FSM state enum and the bus command constants (BUS_NONE, BUS_RD, BUS_RDX, BUS_UPGR) SHALL live in shared package mesi_pkg.
REQ-034 The winner selection SHALL be a combinational sub-module rr_arbiter (inputs req and p; outputs one-hot grant and 2-bit index).

Verification
REQ-035 The bench SHALL cover this case: core 2 read miss (req = 4'b0100, type 0, hit 0) with snoop_shared = 1 -> grant = 4'b0100; bus_signals = 5'b10100 for 2 cycles; done = 4'b0100 with shared_out = 1 at t+4.
REQ-036 The bench SHALL cover this case: core 1 write hit -> bus_signals = 5'b01001; core 3 write miss -> bus_signals = 5'b11010.
REQ-037 The bench SHALL cover this case: core 0 read hit -> no bus_valid; done = 4'b0001 at t+2 with shared_out = 0.
REQ-038 The bench SHALL cover this case: req = 4'b1111 held, round-robin build -> grant order 0, 1, 2, 3, 0; fixed-priority build -> core 0 granted repeatedly.
REQ-039 The bench SHALL cover this case: rst_n pulsed low during SNOOP -> all outputs 0 at once; no done pulse; next grant goes to core 0.

Source files
------------

// File: rtl/mesi_pkg.sv
// -----------------------------------------------------------------------------
// mesi_pkg
// Shared definitions for the MESI snooping-bus arbiter:
//   - mesi_arb_state_e : arbiter FSM states (IDLE, GRANT, SNOOP, RESP)
//   - BUS_*            : 3-bit bus command codes {BusRd, BusRdX, BusUpgr}
//   - bus_cmd()        : maps a latched access type / L1 hit flag to a command
//   - is_read_hit()    : read hits need no bus broadcast
// -----------------------------------------------------------------------------
package mesi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_SNOOP = 2'b10,
    ST_RESP  = 2'b11
  } mesi_arb_state_e;

  localparam logic [2:0] BUS_NONE = 3'b000;
  localparam logic [2:0] BUS_RD   = 3'b100;
  localparam logic [2:0] BUS_RDX  = 3'b010;
  localparam logic [2:0] BUS_UPGR = 3'b001;

  // is_write: 1 = write access; is_hit: 1 = line present in the requester's L1
  function automatic logic [2:0] bus_cmd(input logic is_write, input logic is_hit);
    logic [2:0] cmd;
    case ({is_write, is_hit})
      2'b00:   cmd = BUS_RD;
      2'b10:   cmd = BUS_RDX;
      2'b11:   cmd = BUS_UPGR;
      2'b01:   cmd = BUS_NONE;
      default: cmd = BUS_NONE;
    endcase
    return cmd;
  endfunction

  function automatic logic is_read_hit(input logic is_write, input logic is_hit);
    return (!is_write) && is_hit;
  endfunction

endpackage

// File: rtl/mesi_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mesi_bus_arbiter_if
// Request/response bundle between the cores and the snooping-bus arbiter.
//   req, req_ins_type, req_hit : per-core request, type (1 = write), L1 hit
//   snoop_shared               : wired-OR shared line from snooping caches
//   grant, done                : one-hot grant / one-cycle completion pulse
//   bus_valid, bus_signals     : broadcast command {core_id, BusRd, BusRdX, BusUpgr}
//   shared_out, busy           : latched shared result, arbiter not idle
// Modports: master = core side (drives requests), slave = arbiter side.
// -----------------------------------------------------------------------------
interface mesi_bus_arbiter_if;

  logic [3:0] req;
  logic [3:0] req_ins_type;
  logic [3:0] req_hit;
  logic       snoop_shared;
  logic [3:0] grant;
  logic       bus_valid;
  logic [4:0] bus_signals;
  logic [3:0] done;
  logic       shared_out;
  logic       busy;

  modport master (
    output req, req_ins_type, req_hit, snoop_shared,
    input  grant, bus_valid, bus_signals, done, shared_out, busy
  );

  modport slave (
    input  req, req_ins_type, req_hit, snoop_shared,
    output grant, bus_valid, bus_signals, done, shared_out, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational winner selection for four requesters. The search starts at
// pointer p and wraps; the first requesting core found wins. Driving p = 0
// gives fixed priority (core 0 highest).
//   req   : request vector          p   : search start index
//   grant : one-hot winner (0 if none)   idx : winner index
// -----------------------------------------------------------------------------
module rr_arbiter (
  input  logic [3:0] req,
  input  logic [1:0] p,
  output logic [3:0] grant,
  output logic [1:0] idx
);

  logic       found_s;
  logic [1:0] cand_s;

  // Walk the four candidates starting at p, keep the first requester.
  always_comb begin
    grant   = 4'b0000;
    idx     = 2'b00;
    found_s = 1'b0;
    cand_s  = 2'b00;
    for (int i = 0; i < 4; i++) begin
      cand_s = p + 2'(i);
      if (!found_s && req[cand_s]) begin
        found_s       = 1'b1;
        idx           = cand_s;
        grant[cand_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/mesi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mesi_bus_arbiter
// Snooping-bus arbiter for four MESI L1 caches. One transaction at a time:
// IDLE -> GRANT -> SNOOP (SNOOP_CYCLES cycles) -> RESP -> IDLE; read hits skip
// SNOOP. All outputs are registered.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mesi_bus_arbiter_if.slave (requests in, grant/bus/done out)
// Build option:
//   MESI_ARB_FIXED_PRIO_EN defined -> fixed priority (core 0 highest);
//   undefined (default)            -> round-robin with pointer p.
// -----------------------------------------------------------------------------
module mesi_bus_arbiter
  import mesi_pkg::*;
#(
  parameter int SNOOP_CYCLES = 2,
  parameter int NUM_CORES    = 4
) (
  input logic               clk,
  input logic               rst_n,
  mesi_bus_arbiter_if.slave bus
);

  mesi_arb_state_e        state_r;
  logic [1:0]             core_id_r;
  logic                   ins_type_r;
  logic                   hit_r;
  logic [3:0]             snoop_cnt_r;
  logic [NUM_CORES-1:0]   grant_r;
  logic [NUM_CORES-1:0]   done_r;
  logic                   bus_valid_r;
  logic [4:0]             bus_signals_r;
  logic                   shared_out_r;
  logic                   busy_r;

  logic                   req_any_s;
  logic [NUM_CORES-1:0]   arb_grant_s;
  logic [1:0]             arb_idx_s;
  logic [1:0]             p_s;

  assign req_any_s = |bus.req;

  rr_arbiter u_rr_arbiter (
    .req   (bus.req),
    .p     (p_s),
    .grant (arb_grant_s),
    .idx   (arb_idx_s)
  );

`ifdef MESI_ARB_FIXED_PRIO_EN
  // Search always starts at core 0.
  assign p_s = 2'b00;
`else
  logic [1:0] p_r;

  // Round-robin pointer: next search starts just after the last winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_r <= 2'b00;
    end else if ((state_r == ST_IDLE) && req_any_s) begin
      p_r <= arb_idx_s + 2'd1;
    end else begin
      p_r <= p_r;
    end
  end

  assign p_s = p_r;
`endif

  // Transaction FSM; outputs are loaded on the transition into each state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      core_id_r     <= 2'b00;
      ins_type_r    <= 1'b0;
      hit_r         <= 1'b0;
      snoop_cnt_r   <= 4'd0;
      grant_r       <= {NUM_CORES{1'b0}};
      done_r        <= {NUM_CORES{1'b0}};
      bus_valid_r   <= 1'b0;
      bus_signals_r <= 5'b00000;
      shared_out_r  <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_any_s) begin
            state_r    <= ST_GRANT;
            core_id_r  <= arb_idx_s;
            ins_type_r <= bus.req_ins_type[arb_idx_s];
            hit_r      <= bus.req_hit[arb_idx_s];
            grant_r    <= arb_grant_s;
            busy_r     <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (is_read_hit(ins_type_r, hit_r)) begin
            // Nothing to broadcast: complete with shared_out forced low.
            state_r      <= ST_RESP;
            done_r       <= grant_r;
            shared_out_r <= 1'b0;
          end else begin
            state_r       <= ST_SNOOP;
            bus_valid_r   <= 1'b1;
            bus_signals_r <= {core_id_r, bus_cmd(ins_type_r, hit_r)};
            snoop_cnt_r   <= 4'd1;
          end
        end
        ST_SNOOP: begin
          // snoop_cnt_r counts the SNOOP cycle currently on the bus.
          if (snoop_cnt_r == 4'(SNOOP_CYCLES)) begin
            state_r       <= ST_RESP;
            bus_valid_r   <= 1'b0;
            bus_signals_r <= 5'b00000;
            done_r        <= grant_r;
            shared_out_r  <= bus.snoop_shared;
          end else begin
            snoop_cnt_r <= snoop_cnt_r + 4'd1;
          end
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          grant_r      <= {NUM_CORES{1'b0}};
          done_r       <= {NUM_CORES{1'b0}};
          shared_out_r <= 1'b0;
          busy_r       <= 1'b0;
        end
        default: begin
          state_r       <= ST_IDLE;
          grant_r       <= {NUM_CORES{1'b0}};
          done_r        <= {NUM_CORES{1'b0}};
          bus_valid_r   <= 1'b0;
          bus_signals_r <= 5'b00000;
          shared_out_r  <= 1'b0;
          busy_r        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant       = grant_r;
  assign bus.done        = done_r;
  assign bus.bus_valid   = bus_valid_r;
  assign bus.bus_signals = bus_signals_r;
  assign bus.shared_out  = shared_out_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_mesi_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mesi_bus_arbiter
// Self-checking bench for mesi_bus_arbiter. A transaction-level reference
// model tracks the age of the current transaction (cycles since grant) and
// derives every expected output from the latency rules; directed transactions
// and a randomized run are both checked against it every cycle.
// -----------------------------------------------------------------------------
module tb_mesi_bus_arbiter;

  localparam int S = 2;

`ifdef MESI_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mesi_bus_arbiter_if bus ();

  mesi_bus_arbiter #(.SNOOP_CYCLES(S), .NUM_CORES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int         m_age = 0;     // 0 = idle, 1 = grant cycle, ...
  int         m_p   = 0;
  logic [1:0] m_w   = 2'd0;
  logic       m_type = 1'b0;
  logic       m_hit  = 1'b0;
  logic       m_rh   = 1'b0;
  logic       m_sh   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return 0;
  endfunction

  function automatic int onehot_idx(input logic [3:0] g);
    for (int i = 0; i < 4; i++) begin
      if (g[i]) return i;
    end
    return -1;
  endfunction

  function automatic int end_age();
    return m_rh ? 2 : 2 + S;
  endfunction

  // advance one clock, update the model with the inputs seen at the edge, check outputs
  task automatic step();
    logic [3:0] eg;
    logic [3:0] ed;
    logic       ebv;
    logic [4:0] ebs;
    logic [2:0] cmd;
    @(posedge clk);
    if (!rst_n) begin
      m_age = 0;
      m_p   = 0;
    end else if (m_age == 0) begin
      if (bus.req != 4'b0000) begin
        m_w    = 2'(pick(bus.req, FIXED_PRIO ? 0 : m_p));
        m_type = bus.req_ins_type[m_w];
        m_hit  = bus.req_hit[m_w];
        m_rh   = !m_type && m_hit;
        m_sh   = 1'b0;
        m_age  = 1;
        m_p    = (int'(m_w) + 1) % 4;
      end
    end else begin
      if (!m_rh && m_age == 1 + S) m_sh = bus.snoop_shared;
      m_age++;
      if (m_age > end_age()) m_age = 0;
    end
    #1;
    if (m_rh) cmd = 3'b000;
    else if (!m_type) cmd = 3'b100;
    else if (m_hit) cmd = 3'b001;
    else cmd = 3'b010;
    eg  = (m_age >= 1) ? (4'b0001 << m_w) : 4'b0000;
    ebv = (!m_rh && m_age >= 2 && m_age <= 1 + S);
    ebs = ebv ? {m_w, cmd} : 5'b00000;
    ed  = (m_age == end_age()) ? (4'b0001 << m_w) : 4'b0000;
    check_eq("grant", bus.grant, eg);
    check_eq("bus_valid", bus.bus_valid, ebv);
    check_eq("bus_signals", bus.bus_signals, ebs);
    check_eq("done", bus.done, ed);
    check_eq("busy", bus.busy, m_age != 0);
    if (m_age == end_age()) check_eq("shared_out", bus.shared_out, m_sh);
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_grant"}, bus.grant, 4'b0000);
    check_eq({pfx, "_bus_valid"}, bus.bus_valid, 1'b0);
    check_eq({pfx, "_bus_signals"}, bus.bus_signals, 5'b00000);
    check_eq({pfx, "_done"}, bus.done, 4'b0000);
    check_eq({pfx, "_shared_out"}, bus.shared_out, 1'b0);
    check_eq({pfx, "_busy"}, bus.busy, 1'b0);
  endtask

  // single-core transaction from IDLE, checked against literal expectations
  task automatic run_tx(input int core, input logic typ, input logic hit, input logic sh,
                        input logic [4:0] exp_bs, input int exp_lat, input logic exp_sh);
    int         lat;
    logic [3:0] seen_g;
    logic [4:0] seen_bs;
    logic       seen_bv;
    lat     = 0;
    seen_g  = 4'b0000;
    seen_bs = 5'b00000;
    seen_bv = 1'b0;
    bus.req          = 4'b0001 << core;
    bus.req_ins_type = {4{typ}};
    bus.req_hit      = {4{hit}};
    bus.snoop_shared = sh;
    for (int k = 0; k < 20; k++) begin
      step();
      lat++;
      if (lat == 1) seen_g = bus.grant;
      if (bus.bus_valid) begin
        seen_bv = 1'b1;
        seen_bs = bus.bus_signals;
      end
      if (bus.done != 4'b0000) break;
    end
    check_eq("tx_grant", seen_g, 4'b0001 << core);
    check_eq("tx_latency", lat, exp_lat);
    check_eq("tx_done", bus.done, 4'b0001 << core);
    check_eq("tx_shared_out", bus.shared_out, exp_sh);
    check_eq("tx_bus_valid_seen", seen_bv, typ | !hit);
    check_eq("tx_bus_signals", seen_bs, exp_bs);
    bus.req = 4'b0000;
    step();
  endtask

  initial begin
    int         got[$];
    int         exp_order[5];
    logic [3:0] prev_g;

    bus.req          = 4'b0000;
    bus.req_ins_type = 4'b0000;
    bus.req_hit      = 4'b0000;
    bus.snoop_shared = 1'b0;

    step();
    step();
    check_zero("reset");
    #2 rst_n = 1'b1;
    step();

    // read miss, write hit, write miss, read hit
    run_tx(2, 1'b0, 1'b0, 1'b1, 5'b10100, 2 + S, 1'b1);
    run_tx(1, 1'b1, 1'b1, 1'b0, 5'b01001, 2 + S, 1'b0);
    run_tx(3, 1'b1, 1'b0, 1'b1, 5'b11010, 2 + S, 1'b1);
    run_tx(0, 1'b0, 1'b1, 1'b1, 5'b00000, 2, 1'b0);

    // reset pulse in the middle of SNOOP
    bus.req          = 4'b0010;
    bus.req_ins_type = 4'b1111;
    bus.req_hit      = 4'b0000;
    step();
    step();
    check_eq("pre_reset_bus_valid", bus.bus_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    m_age = 0;
    m_p   = 0;
    #1 rst_n = 1'b1;

    // all four cores requesting, held
    bus.req = 4'b1111;
    prev_g  = 4'b0000;
    for (int k = 0; k < 80 && got.size() < 5; k++) begin
      step();
      if (bus.grant != 4'b0000 && prev_g == 4'b0000) got.push_back(onehot_idx(bus.grant));
      prev_g = bus.grant;
    end
    for (int k = 0; k < 5; k++) exp_order[k] = FIXED_PRIO ? 0 : (k % 4);
    for (int k = 0; k < 5; k++) begin
      check_eq("grant_order", (k < got.size()) ? got[k] : -1, exp_order[k]);
    end
    bus.req = 4'b0000;
    for (int k = 0; k < 8; k++) step();

    // randomized traffic, including requests that drop or appear mid-transaction
    for (int k = 0; k < 400; k++) begin
      bus.req          = 4'($urandom_range(0, 15));
      bus.req_ins_type = 4'($urandom_range(0, 15));
      bus.req_hit      = 4'($urandom_range(0, 15));
      bus.snoop_shared = 1'($urandom_range(0, 1));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

endmodule
